// File: rtl/crossing_phase_scheduler_pkg.sv
// Shared definitions for the main/side crossing scheduler: phase encodings,
// default durations and the Moore lamp decode.
package crossing_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    S_MG     = 3'd0,
    S_MY     = 3'd1,
    S_ALLRED = 3'd2,
    S_SG     = 3'd3,
    S_SY     = 3'd4,
    S_WALK   = 3'd5
  } state_e;

  // Where an all-red interval leads: back to main green, or to a requester.
  typedef enum logic {
    NXT_MG    = 1'b0,
    NXT_SERVE = 1'b1
  } nxt_e;

  localparam int unsigned DEF_CNT_W      = 6;
  localparam int unsigned DEF_T_MAIN_MIN = 59;
  localparam int unsigned DEF_T_SIDE_GRN = 29;
  localparam int unsigned DEF_T_YELLOW   = 4;
  localparam int unsigned DEF_T_ALLRED   = 2;
  localparam int unsigned DEF_T_WALK     = 29;

  typedef struct packed {
    logic main_red;
    logic main_yellow;
    logic main_green;
    logic side_red;
    logic side_yellow;
    logic side_green;
    logic ped_green;
  } lamps_t;

  function automatic lamps_t decode_lamps(state_e s);
    lamps_t l;
    l = '0;
    case (s)
      S_MG:    begin l.main_green  = 1'b1; l.side_red   = 1'b1; end
      S_MY:    begin l.main_yellow = 1'b1; l.side_red   = 1'b1; end
      S_SG:    begin l.main_red    = 1'b1; l.side_green = 1'b1; end
      S_SY:    begin l.main_red    = 1'b1; l.side_yellow = 1'b1; end
      S_WALK:  begin l.main_red    = 1'b1; l.side_red   = 1'b1; l.ped_green = 1'b1; end
      default: begin l.main_red    = 1'b1; l.side_red   = 1'b1; end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/crossing_phase_scheduler_phase_timer.sv
// Phase down-counter: loads a value, otherwise decrements and sticks at zero.
module phase_timer #(
  parameter int unsigned          CNT_W   = 6,
  parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_cnt <= RST_VAL;
    else if (i_load)          r_cnt <= i_value;
    else if (r_cnt != '0)     r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/crossing_phase_scheduler.sv
// Main/side intersection phase scheduler with an all-way pedestrian WALK;
// pedestrian and side-road requests share the red interval round-robin.
module crossing_phase_scheduler
  import crossing_phase_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned T_MAIN_MIN = DEF_T_MAIN_MIN,
  parameter int unsigned T_SIDE_GRN = DEF_T_SIDE_GRN,
  parameter int unsigned T_YELLOW   = DEF_T_YELLOW,
  parameter int unsigned T_ALLRED   = DEF_T_ALLRED,
  parameter int unsigned T_WALK     = DEF_T_WALK
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_btn,
  input  logic             i_car_side,
  output logic             o_main_red,
  output logic             o_main_yellow,
  output logic             o_main_green,
  output logic             o_side_red,
  output logic             o_side_yellow,
  output logic             o_side_green,
  output logic             o_ped_green,
  output logic             o_ped_red,
  output logic             o_ped_wait,
  output logic [CNT_W-1:0] o_timer
);

  localparam logic [CNT_W-1:0] L_MAIN   = CNT_W'(T_MAIN_MIN - 1);
  localparam logic [CNT_W-1:0] L_SIDE   = CNT_W'(T_SIDE_GRN - 1);
  localparam logic [CNT_W-1:0] L_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] L_WALK   = CNT_W'(T_WALK - 1);

  state_e           r_state, w_state_n;
  nxt_e             r_nxt, w_nxt_n;
  logic             r_ped_req, r_car_req, r_rr;
  logic             w_zero, w_load;
  logic [CNT_W-1:0] w_cnt, w_load_val;
  lamps_t           w_lamps;

  phase_timer #(.CNT_W(CNT_W), .RST_VAL(L_ALLRED)) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_cnt   (w_cnt),
    .o_zero  (w_zero)
  );

  always_comb begin
    w_state_n = r_state;
    w_nxt_n   = r_nxt;
    if (w_zero) begin
      case (r_state)
        S_MG:     if (r_ped_req || r_car_req) w_state_n = S_MY;
        S_MY:     begin w_state_n = S_ALLRED; w_nxt_n = NXT_SERVE; end
        S_SG:     w_state_n = S_SY;
        S_SY,
        S_WALK:   begin w_state_n = S_ALLRED; w_nxt_n = NXT_MG; end
        S_ALLRED: begin
          // Ped wins a tie only when rr says it is ped's turn.
          if (r_nxt == NXT_MG)                          w_state_n = S_MG;
          else if (r_ped_req && (!r_car_req || !r_rr))  w_state_n = S_WALK;
          else if (r_car_req)                           w_state_n = S_SG;
          else                                          w_state_n = S_MG;
        end
        default:  w_state_n = S_ALLRED;
      endcase
    end
  end

  assign w_load = (w_state_n != r_state);

  always_comb begin
    case (w_state_n)
      S_MG:          w_load_val = L_MAIN;
      S_MY, S_SY:    w_load_val = L_YELLOW;
      S_SG:          w_load_val = L_SIDE;
      S_WALK:        w_load_val = L_WALK;
      default:       w_load_val = L_ALLRED;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_ALLRED;
      r_nxt     <= NXT_MG;
      r_ped_req <= 1'b0;
      r_car_req <= 1'b0;
      r_rr      <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_nxt   <= w_nxt_n;
      // Requests are blanked for the whole of their own service phase.
      if (r_state == S_WALK || w_state_n == S_WALK) r_ped_req <= 1'b0;
      else                                          r_ped_req <= r_ped_req | i_btn;
      if (r_state == S_SG || w_state_n == S_SG)     r_car_req <= 1'b0;
      else                                          r_car_req <= r_car_req | i_car_side;
      if (w_load && w_state_n == S_WALK)            r_rr <= 1'b1;
      else if (w_load && w_state_n == S_SG)         r_rr <= 1'b0;
    end
  end

  assign w_lamps       = decode_lamps(r_state);
  assign o_main_red    = w_lamps.main_red;
  assign o_main_yellow = w_lamps.main_yellow;
  assign o_main_green  = w_lamps.main_green;
  assign o_side_red    = w_lamps.side_red;
  assign o_side_yellow = w_lamps.side_yellow;
  assign o_side_green  = w_lamps.side_green;
  assign o_ped_green   = w_lamps.ped_green;
  assign o_ped_red     = ~w_lamps.ped_green;
  assign o_ped_wait    = r_ped_req;
  assign o_timer       = w_cnt;

endmodule

// File: tb/tb_crossing_phase_scheduler.sv
// Bench for crossing_phase_scheduler: phase/elapsed-time reference model,
// per-cycle compare, run-length log of lamp patterns for directed checks.
module tb_crossing_phase_scheduler;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn = 1'b0;
  logic             car_side = 1'b0;
  logic             main_red, main_yellow, main_green;
  logic             side_red, side_yellow, side_green;
  logic             ped_green, ped_red, ped_wait;
  logic [CNT_W-1:0] timer;

  always #5 clk = ~clk;

  crossing_phase_scheduler dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_btn        (btn),
    .i_car_side   (car_side),
    .o_main_red   (main_red),
    .o_main_yellow(main_yellow),
    .o_main_green (main_green),
    .o_side_red   (side_red),
    .o_side_yellow(side_yellow),
    .o_side_green (side_green),
    .o_ped_green  (ped_green),
    .o_ped_red    (ped_red),
    .o_ped_wait   (ped_wait),
    .o_timer      (timer)
  );

  // Lamp patterns {mr,my,mg,sr,sy,sg,pg,pr}
  localparam logic [7:0] P_MG = 8'b0011_0001;
  localparam logic [7:0] P_MY = 8'b0101_0001;
  localparam logic [7:0] P_AR = 8'b1001_0001;
  localparam logic [7:0] P_SG = 8'b1000_0101;
  localparam logic [7:0] P_SY = 8'b1000_1001;
  localparam logic [7:0] P_WK = 8'b1001_0010;

  localparam int PH_MG = 0, PH_MY = 1, PH_AR = 2, PH_SG = 3, PH_SY = 4, PH_WK = 5;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dur(input int ph);
    case (ph)
      PH_MG:   return 59;
      PH_MY:   return 4;
      PH_SG:   return 29;
      PH_SY:   return 4;
      PH_WK:   return 29;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] pattern(input int ph);
    case (ph)
      PH_MG:   return P_MG;
      PH_MY:   return P_MY;
      PH_SG:   return P_SG;
      PH_SY:   return P_SY;
      PH_WK:   return P_WK;
      default: return P_AR;
    endcase
  endfunction

  // Reference model: current phase plus cycles already spent in it.
  int m_ph = PH_AR, m_el = 0;
  bit m_ped = 0, m_car = 0, m_rr = 0, m_serve = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ph = PH_AR; m_el = 0; m_ped = 0; m_car = 0; m_rr = 0; m_serve = 0;
      end else begin
        int nx;
        bit ns;
        nx = m_ph;
        ns = m_serve;
        if (m_el >= dur(m_ph) - 1) begin
          case (m_ph)
            PH_MG: if (m_ped || m_car) nx = PH_MY;
            PH_MY: begin nx = PH_AR; ns = 1; end
            PH_SG: nx = PH_SY;
            PH_SY, PH_WK: begin nx = PH_AR; ns = 0; end
            default: begin
              if (!m_serve)             nx = PH_MG;
              else if (m_ped && m_car)  nx = m_rr ? PH_SG : PH_WK;
              else if (m_ped)           nx = PH_WK;
              else if (m_car)           nx = PH_SG;
              else                      nx = PH_MG;
            end
          endcase
        end
        m_ped = (nx == PH_WK || m_ph == PH_WK) ? 1'b0 : (m_ped | btn);
        m_car = (nx == PH_SG || m_ph == PH_SG) ? 1'b0 : (m_car | car_side);
        if (nx != m_ph) begin
          if (nx == PH_WK) m_rr = 1;
          if (nx == PH_SG) m_rr = 0;
          m_el = 0;
        end else if (m_el < 1000) begin
          m_el++;
        end
        m_ph = nx;
        m_serve = ns;
      end
    end
  end

  wire [7:0] dut_lamps = {main_red, main_yellow, main_green, side_red,
                          side_yellow, side_green, ped_green, ped_red};

  logic [7:0] prev_l;
  int         cur_len = 0;
  logic [7:0] rl_pat[$];
  int         rl_len[$];

  function automatic int run_len(input int i);
    return (i < rl_len.size()) ? rl_len[i] : -1;
  endfunction

  function automatic int run_pat(input int i);
    return (i < rl_pat.size()) ? int'(rl_pat[i]) : -1;
  endfunction

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      int et;
      logic ok;
      @(negedge clk);
      #1;
      et = dur(m_ph) - 1 - m_el;
      if (et < 0) et = 0;
      chk("lamps", dut_lamps, pattern(m_ph));
      chk("timer", timer, et);
      chk("ped_wait", ped_wait, m_ped);
      ok = !((main_green | main_yellow) && (side_green | side_yellow)) &&
           $onehot({main_red, main_yellow, main_green}) &&
           $onehot({side_red, side_yellow, side_green}) &&
           (ped_red == ~ped_green) && (!ped_green || (main_red && side_red));
      chk("safety", ok, 1);
      if (rst) begin
        prev_l = dut_lamps; cur_len = 0;
      end else if (dut_lamps == prev_l) begin
        cur_len++;
      end else begin
        rl_pat.push_back(prev_l); rl_len.push_back(cur_len);
        prev_l = dut_lamps; cur_len = 1;
      end
    end
  end

  function automatic logic sig_of(input int which);
    case (which)
      0:       return main_green;
      1:       return ped_green;
      2:       return side_green;
      3:       return side_yellow;
      default: return (timer == '0) && main_green;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input int maxc);
    int k;
    k = 0;
    while (!sig_of(which) && k < maxc) begin
      @(negedge clk);
      k++;
    end
    chk(name, sig_of(which), 1);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst = 1'b1;
    rl_pat.delete(); rl_len.delete();
    repeat (ncyc) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // 1: reset state, then ALLRED 2 and MG holding at timer 0
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("t1_rst_timer", timer, 1);
    chk("t1_rst_lamps", dut_lamps, P_AR);
    chk("t1_rst_wait", ped_wait, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (130) @(negedge clk);
    #2;
    chk("t1_runs", rl_pat.size(), 1);
    chk("t1_ar_len", run_len(0), 2);
    chk("t1_mg_hold", main_green, 1);
    chk("t1_timer0", timer, 0);

    // 2: button pulse at MG cycle 10 -> full ped service
    do_reset(1);
    wait_sig("t2_wait_mg", 0, 10);
    repeat (9) @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    #2;
    chk("t2_ped_wait", ped_wait, 1);
    repeat (110) @(negedge clk);
    chk("t2_r0", run_pat(0), P_AR); chk("t2_l0", run_len(0), 2);
    chk("t2_r1", run_pat(1), P_MG); chk("t2_l1", run_len(1), 59);
    chk("t2_r2", run_pat(2), P_MY); chk("t2_l2", run_len(2), 4);
    chk("t2_r3", run_pat(3), P_AR); chk("t2_l3", run_len(3), 2);
    chk("t2_r4", run_pat(4), P_WK); chk("t2_l4", run_len(4), 29);
    chk("t2_r5", run_pat(5), P_AR); chk("t2_l5", run_len(5), 2);
    chk("t2_back_mg", main_green, 1);

    // 3: both requests held -> WALK, SG, WALK
    @(negedge clk);
    rst = 1'b1; btn = 1'b1; car_side = 1'b1;
    rl_pat.delete(); rl_len.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    btn = 1'b0; car_side = 1'b0;
    chk("t3_first", run_pat(4), P_WK);
    chk("t3_second", run_pat(9), P_SG);
    chk("t3_sg_len", run_len(9), 29);
    chk("t3_third", run_pat(15), P_WK);

    // 4: car pulse at MG timer 0; car held through SG does not re-request
    do_reset(1);
    wait_sig("t4_wait_t0", 4, 80);
    repeat (3) @(negedge clk);
    car_side = 1'b1;
    @(negedge clk);
    car_side = 1'b0;
    #2;
    chk("t4_still_mg", main_green, 1);
    @(negedge clk);
    #2;
    chk("t4_my", main_yellow, 1);
    wait_sig("t4_wait_sg", 2, 20);
    car_side = 1'b1;
    wait_sig("t4_wait_sy", 3, 40);
    car_side = 1'b0;
    repeat (150) @(negedge clk);
    chk("t4_sg_pat", run_pat(4), P_SG);
    chk("t4_sg_len", run_len(4), 29);
    chk("t4_runs", rl_pat.size(), 7);
    chk("t4_mg_hold", main_green, 1);

    // 5: reset mid-WALK drops everything at once
    do_reset(1);
    btn = 1'b1; car_side = 1'b1;
    @(negedge clk);
    btn = 1'b0; car_side = 1'b0;
    wait_sig("t5_wait_walk", 1, 150);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    rl_pat.delete(); rl_len.delete();
    #2;
    chk("t5_ped_green", ped_green, 0);
    chk("t5_main_red", main_red, 1);
    chk("t5_side_red", side_red, 1);
    chk("t5_ped_wait", ped_wait, 0);
    chk("t5_timer", timer, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("t5_runs", rl_pat.size(), 1);
    chk("t5_mg_hold", main_green, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
